// File: rtl/branch_pkg.sv
// Shared types and constants for the branch-code handshake stage.
// Contents:
//   state_t  - handshake FSM states (IDLE, REQ_HI, REQ_LO, ERR)
//   code_t   - two-bit branch code; CODE_ELSE/CODE_IF/CODE_ELSIF
//   classify - maps the upstream pair {in0,in1} to the branch taken
package branch_pkg;

  localparam int unsigned CODE_W = 2;

  typedef logic [CODE_W-1:0] code_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2,
    ERR    = 2'd3
  } state_t;

  localparam code_t CODE_ELSE  = 2'd0;
  localparam code_t CODE_IF    = 2'd1;
  localparam code_t CODE_ELSIF = 2'd2;

  // First-match priority of the conditional stage: in0 alone means the
  // if-branch fired, in1 alone the else-if; both or neither fall to else.
  function automatic code_t classify(input logic in0, input logic in1);
    code_t c;
    c = CODE_ELSE;
    if (in0 && !in1) begin
      c = CODE_IF;
    end else if (!in0 && in1) begin
      c = CODE_ELSIF;
    end
    return c;
  endfunction

endpackage

// File: rtl/branch_code_handshake_if.sv
// Bus between the conditional stage, this block and the next stage.
// Signals:
//   in0, in1, in_valid, in_ready - upstream valid/ready pair transfer
//   req, ack, code               - four-phase handshake toward downstream
// Modports:
//   slave  - the handshake block
//   master - the surrounding environment (upstream source + downstream sink)
interface branch_code_handshake_if;
  import branch_pkg::*;

  logic  in0;
  logic  in1;
  logic  in_valid;
  logic  in_ready;
  logic  req;
  logic  ack;
  code_t code;

  modport slave (
    input  in0,
    input  in1,
    input  in_valid,
    input  ack,
    output in_ready,
    output req,
    output code
  );

  modport master (
    output in0,
    output in1,
    output in_valid,
    output ack,
    input  in_ready,
    input  req,
    input  code
  );

endinterface

// File: rtl/branch_classify.sv
// Combinational classifier of the conditional-stage pair into a branch code.
// Ports:
//   in0, in1 - upstream pair
//   code     - CODE_IF for 2'b10, CODE_ELSIF for 2'b01, CODE_ELSE otherwise
module branch_classify
  import branch_pkg::*;
(
  input  logic  in0,
  input  logic  in1,
  output code_t code
);

  always_comb begin
    code = classify(in0, in1);
  end

endmodule

// File: rtl/branch_code_handshake.sv
// Accepts the conditional-stage pair, classifies it, and delivers the branch
// code over a four-phase req/ack handshake; counts completed handshakes.
// Optional macro ACK_TIMEOUT_EN adds an ack-timeout watchdog (ERR state,
// sticky err); without it REQ_HI waits indefinitely and err is tied low.
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset
//   bus   - slave side of branch_code_handshake_if (pair in, req/ack/code out)
//   count - completed handshakes, wraps at 2^CNT_W
//   err   - sticky ack-timeout error
module branch_code_handshake
  import branch_pkg::*;
#(
  parameter int unsigned CNT_W = 4
`ifdef ACK_TIMEOUT_EN
  ,
  parameter int unsigned ACK_TIMEOUT = 15
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  branch_code_handshake_if.slave bus,
  output logic [CNT_W-1:0]     count,
  output logic                 err
);

  state_t state;
  logic   req_q;
  code_t  code_q;
  code_t  class_code;
  logic   accept;

  branch_classify u_classify (
    .in0  (bus.in0),
    .in1  (bus.in1),
    .code (class_code)
  );

  // A still-high ack from the previous transfer must drop before a new accept.
  assign bus.in_ready = (state == IDLE) && !bus.ack && !rst;
  assign accept       = bus.in_valid && bus.in_ready;
  assign bus.req      = req_q;
  assign bus.code     = code_q;

`ifdef ACK_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(ACK_TIMEOUT + 1);

  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] timer_nxt;
  logic             err_q;

  // Cycles spent in REQ_HI without ack, counting the current one.
  assign timer_nxt = timer + TMR_W'(1);
  assign err       = err_q;

  // Handshake FSM with watchdog; ack on the limit cycle beats the timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      req_q  <= 1'b0;
      code_q <= CODE_ELSE;
      count  <= '0;
      err_q  <= 1'b0;
      timer  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            code_q <= class_code;
            req_q  <= 1'b1;
            timer  <= '0;
            state  <= REQ_HI;
          end
        end
        REQ_HI: begin
          if (bus.ack) begin
            req_q <= 1'b0;
            state <= REQ_LO;
          end else if (timer_nxt == TMR_W'(ACK_TIMEOUT)) begin
            req_q <= 1'b0;
            err_q <= 1'b1;
            state <= ERR;
          end else begin
            timer <= timer_nxt;
          end
        end
        REQ_LO: begin
          if (!bus.ack) begin
            count <= count + CNT_W'(1);
            state <= IDLE;
          end
        end
        ERR: begin
          // Only reset leaves the error state.
          req_q <= 1'b0;
        end
        default: begin
          req_q <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
`else
  assign err = 1'b0;

  // Handshake FSM; REQ_HI has no bound on how long it waits for ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      req_q  <= 1'b0;
      code_q <= CODE_ELSE;
      count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            code_q <= class_code;
            req_q  <= 1'b1;
            state  <= REQ_HI;
          end
        end
        REQ_HI: begin
          if (bus.ack) begin
            req_q <= 1'b0;
            state <= REQ_LO;
          end
        end
        REQ_LO: begin
          if (!bus.ack) begin
            count <= count + CNT_W'(1);
            state <= IDLE;
          end
        end
        default: begin
          req_q <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_branch_code_handshake.sv
// Directed bench for branch_code_handshake. A second instance with CNT_W=2
// shares the same input stimulus so counter wrap can be observed.
module tb_branch_code_handshake;
  import branch_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] count;
  logic       err;
  logic [1:0] count2;
  logic       err2;
  int         vectors = 0;
  int         errors  = 0;
  int         cyc_cnt = 0;

  branch_code_handshake_if bus ();
  branch_code_handshake_if bus2 ();

  assign bus2.in0      = bus.in0;
  assign bus2.in1      = bus.in1;
  assign bus2.in_valid = bus.in_valid;
  assign bus2.ack      = bus.ack;

  branch_code_handshake #(.CNT_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .count (count),
    .err   (err)
  );

  branch_code_handshake #(.CNT_W(2)) dut2 (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus2),
    .count (count2),
    .err   (err2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One full transaction: accept, ack after ack_dly cycles, ack release.
  task automatic do_txn(input logic a, input logic b, input int ack_dly,
                        output code_t c, output int t_acc);
    bus.in0 = a;
    bus.in1 = b;
    bus.in_valid = 1'b1;
    cyc();
    t_acc = cyc_cnt;
    c = bus.code;
    bus.in_valid = 1'b0;
    if (ack_dly > 0) cyc(ack_dly);
    bus.ack = 1'b1;
    cyc();
    bus.ack = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.ack = 1'b1;
    bus.in0 = 1'b1;
    bus.in1 = 1'b0;
    bus.in_valid = 1'b1;
    cyc(2);
    vectors++; if (bus.req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b expected 0", bus.req); end
    vectors++; if (bus.code !== 2'd0) begin errors++; $display("FAIL reset_code: got %0d expected 0", bus.code); end
    vectors++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    vectors++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", err); end
    vectors++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b expected 0", bus.in_ready); end
    rst = 1'b0;
    #1;
    vectors++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL ack_blocks_ready: got %0b expected 0", bus.in_ready); end
    cyc(2);
    vectors++; if (bus.req !== 1'b0) begin errors++; $display("FAIL ack_blocks_req: got %0b expected 0", bus.req); end
    bus.in_valid = 1'b0;
    bus.ack = 1'b0;
    #1;
    vectors++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready: got %0b expected 1", bus.in_ready); end
  endtask

  task automatic test_single();
    bus.in0 = 1'b1;
    bus.in1 = 1'b0;
    bus.in_valid = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    vectors++; if (bus.req !== 1'b1) begin errors++; $display("FAIL single_req_rise: got %0b expected 1", bus.req); end
    vectors++; if (bus.code !== 2'd1) begin errors++; $display("FAIL single_code: got %0d expected 1", bus.code); end
    vectors++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL single_busy_ready: got %0b expected 0", bus.in_ready); end
    cyc(2);
    vectors++; if (bus.req !== 1'b1) begin errors++; $display("FAIL single_req_hold: got %0b expected 1", bus.req); end
    bus.ack = 1'b1;
    cyc();
    vectors++; if (bus.req !== 1'b0) begin errors++; $display("FAIL single_req_fall: got %0b expected 0", bus.req); end
    vectors++; if (bus.code !== 2'd1) begin errors++; $display("FAIL single_code_held: got %0d expected 1", bus.code); end
    vectors++; if (count !== 4'd0) begin errors++; $display("FAIL single_count_early: got %0d expected 0", count); end
    bus.ack = 1'b0;
    cyc();
    vectors++; if (count !== 4'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", count); end
    vectors++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL single_ready_back: got %0b expected 1", bus.in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] pairs [4];
    code_t      exp_codes [4];
    code_t      c;
    int         t_acc;
    int         t_prev;
    logic [1:0] p;
    pairs = '{2'b01, 2'b00, 2'b11, 2'b10};
    exp_codes = '{2'd2, 2'd0, 2'd0, 2'd1};
    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      p = pairs[i];
      do_txn(p[1], p[0], 0, c, t_acc);
      vectors++; if (c !== exp_codes[i]) begin errors++; $display("FAIL b2b_code[%0d]: got %0d expected %0d", i, c, exp_codes[i]); end
      if (i > 0) begin
        vectors++; if (t_acc - t_prev !== 3) begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d expected 3", i, t_acc - t_prev); end
      end
      t_prev = t_acc;
    end
    vectors++; if (count !== 4'd5) begin errors++; $display("FAIL b2b_count: got %0d expected 5", count); end
  endtask

  task automatic test_count_wrap();
    logic [1:0] exp2 [5];
    code_t      c;
    int         t_acc;
    exp2 = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    vectors++; if (count2 !== 2'd0) begin errors++; $display("FAIL wrap_reset: got %0d expected 0", count2); end
    for (int i = 0; i < 5; i++) begin
      do_txn(1'b0, 1'b1, 1, c, t_acc);
      vectors++; if (count2 !== exp2[i]) begin errors++; $display("FAIL wrap_count2[%0d]: got %0d expected %0d", i, count2, exp2[i]); end
    end
    vectors++; if (count !== 4'd5) begin errors++; $display("FAIL wrap_count4: got %0d expected 5", count); end
    vectors++; if (bus2.req !== 1'b0) begin errors++; $display("FAIL wrap_req2: got %0b expected 0", bus2.req); end
  endtask

  task automatic test_reset_mid();
    code_t c;
    int    t_acc;
    bus.in0 = 1'b1;
    bus.in1 = 1'b0;
    bus.in_valid = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    vectors++; if (bus.req !== 1'b1) begin errors++; $display("FAIL mid_hi_req_before: got %0b expected 1", bus.req); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    vectors++; if (bus.req !== 1'b0) begin errors++; $display("FAIL mid_hi_req: got %0b expected 0", bus.req); end
    vectors++; if (count !== 4'd0) begin errors++; $display("FAIL mid_hi_count: got %0d expected 0", count); end
    vectors++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_hi_idle: got %0b expected 1", bus.in_ready); end
    do_txn(1'b1, 1'b0, 0, c, t_acc);
    vectors++; if (count !== 4'd1) begin errors++; $display("FAIL mid_count_pre: got %0d expected 1", count); end
    bus.in_valid = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    bus.ack = 1'b1;
    cyc();
    vectors++; if (bus.req !== 1'b0) begin errors++; $display("FAIL mid_lo_req_before: got %0b expected 0", bus.req); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    vectors++; if (count !== 4'd0) begin errors++; $display("FAIL mid_lo_count: got %0d expected 0", count); end
    vectors++; if (bus.code !== 2'd0) begin errors++; $display("FAIL mid_lo_code: got %0d expected 0", bus.code); end
    bus.ack = 1'b0;
    #1;
    vectors++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_lo_idle: got %0b expected 1", bus.in_ready); end
    do_txn(1'b0, 1'b1, 0, c, t_acc);
    vectors++; if (c !== 2'd2) begin errors++; $display("FAIL mid_post_code: got %0d expected 2", c); end
    vectors++; if (count !== 4'd1) begin errors++; $display("FAIL mid_post_count: got %0d expected 1", count); end
  endtask

`ifdef ACK_TIMEOUT_EN
  task automatic test_timeout();
    bus.in0 = 1'b1;
    bus.in1 = 1'b0;
    bus.in_valid = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    cyc(14);
    vectors++; if (bus.req !== 1'b1) begin errors++; $display("FAIL to_req_cycle15: got %0b expected 1", bus.req); end
    vectors++; if (err !== 1'b0) begin errors++; $display("FAIL to_err_early: got %0b expected 0", err); end
    cyc();
    vectors++; if (err !== 1'b1) begin errors++; $display("FAIL to_err: got %0b expected 1", err); end
    vectors++; if (bus.req !== 1'b0) begin errors++; $display("FAIL to_req: got %0b expected 0", bus.req); end
    bus.in_valid = 1'b1;
    cyc(3);
    vectors++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL to_ready: got %0b expected 0", bus.in_ready); end
    vectors++; if (bus.req !== 1'b0) begin errors++; $display("FAIL to_no_accept: got %0b expected 0", bus.req); end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    vectors++; if (err !== 1'b0) begin errors++; $display("FAIL to_err_cleared: got %0b expected 0", err); end
    bus.in_valid = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    cyc(14);
    bus.ack = 1'b1;
    cyc();
    vectors++; if (err !== 1'b0) begin errors++; $display("FAIL to_ack_wins_err: got %0b expected 0", err); end
    vectors++; if (bus.req !== 1'b0) begin errors++; $display("FAIL to_ack_wins_req: got %0b expected 0", bus.req); end
    bus.ack = 1'b0;
    cyc();
    vectors++; if (count !== 4'd1) begin errors++; $display("FAIL to_ack_wins_count: got %0d expected 1", count); end
  endtask
`else
  task automatic test_no_timeout();
    bus.in0 = 1'b1;
    bus.in1 = 1'b1;
    bus.in_valid = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    cyc(20);
    vectors++; if (bus.req !== 1'b1) begin errors++; $display("FAIL nto_req: got %0b expected 1", bus.req); end
    vectors++; if (err !== 1'b0) begin errors++; $display("FAIL nto_err: got %0b expected 0", err); end
    bus.ack = 1'b1;
    cyc();
    bus.ack = 1'b0;
    cyc();
    vectors++; if (count !== 4'd2) begin errors++; $display("FAIL nto_count: got %0d expected 2", count); end
    vectors++; if (bus.code !== 2'd0) begin errors++; $display("FAIL nto_code: got %0d expected 0", bus.code); end
  endtask
`endif

  initial begin
    bus.in0 = 1'b0;
    bus.in1 = 1'b0;
    bus.in_valid = 1'b0;
    bus.ack = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_count_wrap();
    test_reset_mid();
`ifdef ACK_TIMEOUT_EN
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    test_timeout();
`else
    test_no_timeout();
`endif
    vectors++; if (err2 !== 1'b0) begin errors++; $display("FAIL err2_final: got %0b expected 0", err2); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
